lookupfib_arbiter: RTL and testbench
====================================

Name: lookupfib_arbiter

Overview:
Round-robin arbiter and sequencer that shares one lookupfib instance between up to four requesters (one per Ethernet port datapath).
- Accepts level-held lookup requests.
- Issues a single-cycle req/search_ip pulse to lookupfib and waits for its ack.
- Returns the result to the granted requester with a one-cycle ack.
- Guards against a missing ack with a timeout.
- Sits between the per-port RX forwarding logic and lookupfib; only one lookup is ever outstanding.

Parameters:
NPORT, 4, number of requesters (1..4); unused bits of cli_req are ignored.
TIMEOUT, 16'd64, WAIT-state cycles before a lookup is abandoned; must be nonzero.

Ports:
sys_clk  in  1  system clock, 125 MHz
sys_rst_n  in  1  asynchronous active-low reset
cli_req  in  4  per-requester lookup request; held high until that requester's cli_ack
cli_ip  in  128  per-requester search IP; requester i uses bits [32*i+31:32*i]; stable while cli_req[i]=1
cli_ack  out  4  one-hot, one-cycle completion pulse
rsp_dest_ip  out  32  result dest IP, valid when cli_ack != 0
rsp_src_mac  out  48  result source MAC
rsp_dest_mac  out  48  result destination MAC
rsp_forward_port  out  4  result forward port
rsp_timeout  out  1  1 = lookup abandoned; the other rsp_* fields are then 0
fib_req  out  1  to lookupfib.req
fib_search_ip  out  32  to lookupfib.search_ip
fib_ack  in  1  from lookupfib.ack
fib_dest_ip  in  32  from lookupfib.dest_ip
fib_src_mac  in  48  from lookupfib.src_mac
fib_dest_mac  in  48  from lookupfib.dest_mac
fib_forward_port  in  4  from lookupfib.forward_port
stat_grant_cnt  out  64  4 x 16-bit per-requester grant counters; see Optional Feature
stat_timeout_cnt  out  16  timeout counter; see Optional Feature

Behaviour:
Reset and clocking
- Single clock sys_clk; sys_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; rr pointer 0; timeout counter 0; mask 0.
- Reset asserted mid-lookup aborts it: no cli_ack is issued and any later fib_ack is ignored.
- All outputs are registered.

State machine
- IDLE: eligible = cli_req & ~mask (restricted to NPORT bits). If eligible != 0, grant g = the first set bit searching upward from the rr pointer, wrapping. Latch g and cli_ip[g], then go to ISSUE. mask clears every IDLE cycle.
- ISSUE (1 cycle): fib_req=1, fib_search_ip = latched IP. rr pointer <= (g+1) mod NPORT. Clear the timeout counter. Go to WAIT.
- WAIT: fib_req=0, fib_search_ip=0.
  - fib_ack=1: register the fib_* results, rsp_timeout=0, go to DONE.
  - Else the counter increments; when it reaches TIMEOUT-1 with no ack, zero the rsp fields, set rsp_timeout=1, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE (1 cycle): cli_ack[g]=1 with rsp_* valid; mask = one-hot g; go to IDLE. In all other states cli_ack=0 and rsp_* hold their last value.

Other rules
- fib_ack outside WAIT is ignored.
- A requester dropping cli_req during ISSUE/WAIT does not cancel the lookup; cli_ack still pulses.
- Latency with lookupfib ack at WAIT cycle k: cli_req sampled at edge N → fib_req high in cycle N+1 → cli_ack in cycle N+3+k.
- Mask prevents re-granting a requester in the IDLE cycle right after its ack while it deasserts cli_req. Back-to-back grants to other requesters are allowed.

Optional Feature:
LOOKUPFIB_ARB_STATS_EN
- Defined: stat_grant_cnt[16*i+15:16*i] increments on each ISSUE granted to requester i. stat_timeout_cnt increments on each timeout. All counters saturate at 16'hFFFF, reset to 0.
- Undefined: stat ports are present and tied to 0; no counter logic.

Test Plan:
- Single request: cli_req=4'b0001, IP 10.0.20.10; fib model acks 3 cycles after fib_req with forward_port 4'b0010, dest_mac 00a0de1c07e8 → exactly one fib_req with search_ip 0a00140a; cli_ack=4'b0001 with those values; rsp_timeout=0.
- Round robin: cli_req=4'b1111 held, reissued after each ack → grant order 0,1,2,3,0; each requester acked exactly once per round.
- Timeout: fib model never acks, TIMEOUT=8 → cli_ack pulses 8 cycles into WAIT with rsp_timeout=1 and rsp fields 0. A late fib_ack in IDLE produces no cli_ack.
- Ack/timeout collision: fib_ack in the final WAIT cycle → rsp_timeout=0, fib data returned.
- Mask: requester 2 alone keeps cli_req high one cycle after cli_ack → no re-grant in that IDLE cycle; granted the cycle after.
- Reset mid-WAIT: sys_rst_n low for 2 cycles → outputs 0, pointer 0; next request from requester 1 completes normally. With LOOKUPFIB_ARB_STATS_EN, counters read 0 after reset and 1 for requester 1 afterwards.

Source files
------------

// File: rtl/lookupfib_arbiter.sv
// rtl/lookupfib_arbiter.sv - round-robin sequencer sharing one lookupfib among NPORT requesters; stats under LOOKUPFIB_ARB_STATS_EN
module lookupfib_arbiter #(
   parameter int          NPORT   = 4,
   parameter logic [15:0] TIMEOUT = 16'd64
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic [3:0]    cli_req,
   input  logic [127:0]  cli_ip,
   output logic [3:0]    cli_ack,
   output logic [31:0]   rsp_dest_ip,
   output logic [47:0]   rsp_src_mac,
   output logic [47:0]   rsp_dest_mac,
   output logic [3:0]    rsp_forward_port,
   output logic          rsp_timeout,
   output logic          fib_req,
   output logic [31:0]   fib_search_ip,
   input  logic          fib_ack,
   input  logic [31:0]   fib_dest_ip,
   input  logic [47:0]   fib_src_mac,
   input  logic [47:0]   fib_dest_mac,
   input  logic [3:0]    fib_forward_port,
   output logic [63:0]   stat_grant_cnt,
   output logic [15:0]   stat_timeout_cnt
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [3:0]  PORT_MASK = 4'((1 << NPORT) - 1);
   localparam logic [1:0]  LAST_PORT = 2'(NPORT - 1);
   localparam logic [15:0] TMO_LAST  = TIMEOUT - 16'd1;

   state_t      state_q, state_d;
   logic [1:0]  rr_q, rr_d;
   logic [1:0]  grant_q, grant_d;
   logic [3:0]  mask_q, mask_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic [3:0]  cli_ack_q, cli_ack_d;
   logic [31:0] rsp_dest_ip_q, rsp_dest_ip_d;
   logic [47:0] rsp_src_mac_q, rsp_src_mac_d;
   logic [47:0] rsp_dest_mac_q, rsp_dest_mac_d;
   logic [3:0]  rsp_forward_port_q, rsp_forward_port_d;
   logic        rsp_timeout_q, rsp_timeout_d;
   logic        fib_req_q, fib_req_d;
   logic [31:0] fib_search_ip_q, fib_search_ip_d;

   logic [3:0]  eligible;
   logic [1:0]  pick;
   logic        found;
   logic [2:0]  idx;

   // first eligible requester at or above the rr pointer, wrapping at NPORT
   always_comb begin
      eligible = cli_req & ~mask_q & PORT_MASK;
      pick     = rr_q;
      found    = 1'b0;
      idx      = 3'd0;
      for (int i = 0; i < NPORT; i++) begin
         idx = {1'b0, rr_q} + 3'(i);
         if (idx >= 3'(NPORT)) idx = idx - 3'(NPORT);
         if (!found && eligible[idx[1:0]]) begin
            found = 1'b1;
            pick  = idx[1:0];
         end
      end
   end

   // sequencer next-state and registered-output values
   always_comb begin
      state_d            = state_q;
      rr_d               = rr_q;
      grant_d            = grant_q;
      mask_d             = mask_q;
      tmo_cnt_d          = tmo_cnt_q;
      cli_ack_d          = 4'd0;
      fib_req_d          = 1'b0;
      fib_search_ip_d    = 32'd0;
      rsp_dest_ip_d      = rsp_dest_ip_q;
      rsp_src_mac_d      = rsp_src_mac_q;
      rsp_dest_mac_d     = rsp_dest_mac_q;
      rsp_forward_port_d = rsp_forward_port_q;
      rsp_timeout_d      = rsp_timeout_q;
      case (state_q)
         S_IDLE: begin
            mask_d = 4'd0;
            if (found) begin
               grant_d         = pick;
               fib_req_d       = 1'b1;
               fib_search_ip_d = cli_ip[{pick, 5'd0} +: 32];
               state_d         = S_ISSUE;
            end
         end
         S_ISSUE: begin
            rr_d      = (grant_q == LAST_PORT) ? 2'd0 : grant_q + 2'd1;
            tmo_cnt_d = 16'd0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (fib_ack) begin
               rsp_dest_ip_d      = fib_dest_ip;
               rsp_src_mac_d      = fib_src_mac;
               rsp_dest_mac_d     = fib_dest_mac;
               rsp_forward_port_d = fib_forward_port;
               rsp_timeout_d      = 1'b0;
               cli_ack_d          = 4'b0001 << grant_q;
               state_d            = S_DONE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               rsp_dest_ip_d      = 32'd0;
               rsp_src_mac_d      = 48'd0;
               rsp_dest_mac_d     = 48'd0;
               rsp_forward_port_d = 4'd0;
               rsp_timeout_d      = 1'b1;
               cli_ack_d          = 4'b0001 << grant_q;
               state_d            = S_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         S_DONE: begin
            mask_d  = 4'b0001 << grant_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and output registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q            <= S_IDLE;
         rr_q               <= 2'd0;
         grant_q            <= 2'd0;
         mask_q             <= 4'd0;
         tmo_cnt_q          <= 16'd0;
         cli_ack_q          <= 4'd0;
         rsp_dest_ip_q      <= 32'd0;
         rsp_src_mac_q      <= 48'd0;
         rsp_dest_mac_q     <= 48'd0;
         rsp_forward_port_q <= 4'd0;
         rsp_timeout_q      <= 1'b0;
         fib_req_q          <= 1'b0;
         fib_search_ip_q    <= 32'd0;
      end else begin
         state_q            <= state_d;
         rr_q               <= rr_d;
         grant_q            <= grant_d;
         mask_q             <= mask_d;
         tmo_cnt_q          <= tmo_cnt_d;
         cli_ack_q          <= cli_ack_d;
         rsp_dest_ip_q      <= rsp_dest_ip_d;
         rsp_src_mac_q      <= rsp_src_mac_d;
         rsp_dest_mac_q     <= rsp_dest_mac_d;
         rsp_forward_port_q <= rsp_forward_port_d;
         rsp_timeout_q      <= rsp_timeout_d;
         fib_req_q          <= fib_req_d;
         fib_search_ip_q    <= fib_search_ip_d;
      end
   end

   assign cli_ack          = cli_ack_q;
   assign rsp_dest_ip      = rsp_dest_ip_q;
   assign rsp_src_mac      = rsp_src_mac_q;
   assign rsp_dest_mac     = rsp_dest_mac_q;
   assign rsp_forward_port = rsp_forward_port_q;
   assign rsp_timeout      = rsp_timeout_q;
   assign fib_req          = fib_req_q;
   assign fib_search_ip    = fib_search_ip_q;

`ifdef LOOKUPFIB_ARB_STATS_EN
   logic [63:0] grant_cnt_q, grant_cnt_d;
   logic [15:0] timeout_cnt_q, timeout_cnt_d;
   logic        timeout_evt;

   // saturating per-requester grant and timeout counters
   always_comb begin
      grant_cnt_d   = grant_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      timeout_evt   = (state_q == S_WAIT) && !fib_ack && (tmo_cnt_q == TMO_LAST);
      if ((state_q == S_ISSUE) && (grant_cnt_q[{grant_q, 4'd0} +: 16] != 16'hFFFF))
         grant_cnt_d[{grant_q, 4'd0} +: 16] = grant_cnt_q[{grant_q, 4'd0} +: 16] + 16'd1;
      if (timeout_evt && (timeout_cnt_q != 16'hFFFF))
         timeout_cnt_d = timeout_cnt_q + 16'd1;
   end

   // counter registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         grant_cnt_q   <= 64'd0;
         timeout_cnt_q <= 16'd0;
      end else begin
         grant_cnt_q   <= grant_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

   assign stat_grant_cnt   = grant_cnt_q;
   assign stat_timeout_cnt = timeout_cnt_q;
`else
   assign stat_grant_cnt   = 64'd0;
   assign stat_timeout_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lookupfib_arbiter.sv
// tb/tb_lookupfib_arbiter.sv - self-checking bench for lookupfib_arbiter with a lookupfib response model
module tb_lookupfib_arbiter;
   localparam int TMO = 8;

   typedef struct {
      int          port;
      logic [31:0] ip;
      int          d;      // fib_ack this many cycles after fib_req; 0 = never
      logic [3:0]  fport;
      logic [47:0] dmac;
      logic [47:0] smac;
      logic [31:0] dip;
      logic        tmo;    // expected rsp_timeout
      int          lat;    // expected cycles from fib_req to cli_ack
   } vec_t;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b1;
   logic [3:0]    cli_req = 4'd0;
   logic [127:0]  cli_ip = 128'd0;
   logic [3:0]    cli_ack;
   logic [31:0]   rsp_dest_ip;
   logic [47:0]   rsp_src_mac;
   logic [47:0]   rsp_dest_mac;
   logic [3:0]    rsp_forward_port;
   logic          rsp_timeout;
   logic          fib_req;
   logic [31:0]   fib_search_ip;
   logic          fib_ack = 1'b0;
   logic [31:0]   fib_dest_ip = 32'd0;
   logic [47:0]   fib_src_mac = 48'd0;
   logic [47:0]   fib_dest_mac = 48'd0;
   logic [3:0]    fib_forward_port = 4'd0;
   logic [63:0]   stat_grant_cnt;
   logic [15:0]   stat_timeout_cnt;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   fr_cyc = 0;
   int   ack_at = -1;
   int   nreq = 0;
   logic prev_fib_req = 1'b0;
   vec_t sb[$];
   vec_t mdl;
   vec_t mon;
   vec_t vecs[6];

   lookupfib_arbiter #(.NPORT(4), .TIMEOUT(16'(TMO))) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .cli_req(cli_req), .cli_ip(cli_ip), .cli_ack(cli_ack),
      .rsp_dest_ip(rsp_dest_ip), .rsp_src_mac(rsp_src_mac), .rsp_dest_mac(rsp_dest_mac),
      .rsp_forward_port(rsp_forward_port), .rsp_timeout(rsp_timeout),
      .fib_req(fib_req), .fib_search_ip(fib_search_ip), .fib_ack(fib_ack),
      .fib_dest_ip(fib_dest_ip), .fib_src_mac(fib_src_mac), .fib_dest_mac(fib_dest_mac),
      .fib_forward_port(fib_forward_port),
      .stat_grant_cnt(stat_grant_cnt), .stat_timeout_cnt(stat_timeout_cnt)
   );

   initial forever #4 sys_clk = ~sys_clk;
   initial forever begin @(posedge sys_clk); cyc++; end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
   endtask

   function automatic vec_t mk(input int port, input logic [31:0] ip, input int d);
      vec_t e;
      e.port  = port;
      e.ip    = ip;
      e.d     = d;
      e.fport = 4'(port + 5);
      e.dmac  = {16'h00a0, ip};
      e.smac  = {ip, 16'h5a5a};
      e.dip   = ~ip;
      e.tmo   = 1'b0;
      e.lat   = d + 1;
      return e;
   endfunction

   // lookupfib model: checks each fib_req against the scoreboard head and acks after its delay
   initial forever begin
      @(negedge sys_clk);
      if (sys_rst_n && fib_req) begin
         check("fib_req_single_cycle", 64'(prev_fib_req), 64'd0);
         nreq++;
         if (sb.size() == 0) begin
            check("unexpected_fib_req", 64'(fib_req), 64'd0);
         end else begin
            mdl = sb[0];
            check("fib_search_ip", 64'(fib_search_ip), 64'(mdl.ip));
            fr_cyc = cyc;
            ack_at = (mdl.d == 0) ? -1 : cyc + mdl.d;
         end
      end
      prev_fib_req = fib_req;
      if (cyc == ack_at) begin
         fib_ack          = 1'b1;
         fib_dest_ip      = mdl.dip;
         fib_src_mac      = mdl.smac;
         fib_dest_mac     = mdl.dmac;
         fib_forward_port = mdl.fport;
      end else begin
         fib_ack          = 1'b0;
         fib_dest_ip      = $urandom;
         fib_src_mac      = 48'({$urandom, $urandom});
         fib_dest_mac     = 48'({$urandom, $urandom});
         fib_forward_port = 4'($urandom);
      end
   end

   // response monitor: pops the scoreboard on every cli_ack
   initial forever begin
      @(negedge sys_clk);
      if (sys_rst_n && cli_ack != 4'd0) begin
         if (sb.size() == 0) begin
            check("unexpected_cli_ack", 64'(cli_ack), 64'd0);
         end else begin
            mon = sb.pop_front();
            check("cli_ack", 64'(cli_ack), 64'(4'b0001 << mon.port));
            check("rsp_timeout", 64'(rsp_timeout), 64'(mon.tmo));
            check("rsp_dest_ip", 64'(rsp_dest_ip), mon.tmo ? 64'd0 : 64'(mon.dip));
            check("rsp_src_mac", 64'(rsp_src_mac), mon.tmo ? 64'd0 : 64'(mon.smac));
            check("rsp_dest_mac", 64'(rsp_dest_mac), mon.tmo ? 64'd0 : 64'(mon.dmac));
            check("rsp_forward_port", 64'(rsp_forward_port), mon.tmo ? 64'd0 : 64'(mon.fport));
            check("latency", 64'(cyc - fr_cyc), 64'(mon.lat));
            check("fib_req_count", 64'(nreq), 64'd1);
            nreq = 0;
         end
      end
   end

   task automatic wait_ack(output int c, output logic [3:0] a);
      c = -1;
      a = 4'd0;
      for (int n = 0; n < 40; n++) begin
         @(negedge sys_clk); #1;
         if (cli_ack != 4'd0) begin
            c = cyc;
            a = cli_ack;
            break;
         end
      end
      if (c < 0) fail_bound("cli_ack_wait");
   endtask

   task automatic wait_fib_req(output int c);
      c = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge sys_clk); #1;
         if (fib_req) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) fail_bound("fib_req_wait");
   endtask

   task automatic drain();
      int c;
      logic [3:0] a;
      while (sb.size() > 0) begin
         wait_ack(c, a);
         if (c < 0) begin
            sb.delete();
            cli_req = 4'd0;
         end else begin
            cli_req = cli_req & ~a;
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_cli_ack"}, 64'(cli_ack), 64'd0);
      check({tag, "_fib_req"}, 64'(fib_req), 64'd0);
      check({tag, "_fib_search_ip"}, 64'(fib_search_ip), 64'd0);
      check({tag, "_rsp_dest_ip"}, 64'(rsp_dest_ip), 64'd0);
      check({tag, "_rsp_src_mac"}, 64'(rsp_src_mac), 64'd0);
      check({tag, "_rsp_dest_mac"}, 64'(rsp_dest_mac), 64'd0);
      check({tag, "_rsp_forward_port"}, 64'(rsp_forward_port), 64'd0);
      check({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
      check({tag, "_stat_grant_cnt"}, stat_grant_cnt, 64'd0);
      check({tag, "_stat_timeout_cnt"}, 64'(stat_timeout_cnt), 64'd0);
   endtask

   initial begin
      int c;
      int d_ack;
      logic [3:0] a;
      vec_t e;

      vecs[0] = '{0, 32'h0a00140a, 3, 4'b0010, 48'h00a0de1c07e8, 48'h020000000001, 32'h0a000101, 1'b0, 4};
      vecs[1] = '{3, 32'hc0a8010a, 1, 4'b1000, 48'h112233445566, 48'h0a0b0c0d0e0f, 32'hc0a80101, 1'b0, 2};
      vecs[2] = '{1, 32'hac100001, 8, 4'b0100, 48'h665544332211, 48'h0f0e0d0c0b0a, 32'hac1000fe, 1'b0, 9};
      vecs[3] = '{2, 32'h08080808, 12, 4'b0001, 48'haaaaaaaaaaaa, 48'hbbbbbbbbbbbb, 32'h01010101, 1'b1, 9};
      vecs[4] = '{0, 32'h7f000001, 0, 4'b1111, 48'hffffffffffff, 48'h123456789abc, 32'h7f0000fe, 1'b1, 9};
      vecs[5] = '{3, 32'h0a0a0a0a, 5, 4'b0011, 48'h001122334455, 48'h5544332211aa, 32'h0a0a0a01, 1'b0, 6};

      #2 sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      #1 check_outputs_zero("reset");
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      #1 check_outputs_zero("idle");

      // single requests from the table: ack, fast ack, collision, timeout with late ack, no ack
      for (int i = 0; i < 6; i++) begin
         e = vecs[i];
         sb.push_back(e);
         cli_ip[32*e.port +: 32] = e.ip;
         cli_req[e.port] = 1'b1;
         drain();
         repeat (6) @(negedge sys_clk);
         #1;
      end

      // round robin: all four held, requester 0 reissues after its first ack
      for (int i = 0; i < 4; i++) begin
         e = mk(i, 32'hc0a80010 + 32'(i), 2);
         sb.push_back(e);
         cli_ip[32*i +: 32] = e.ip;
      end
      cli_req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_ack(c, a);
         if (c < 0) begin
            sb.delete();
            break;
         end
         cli_req = cli_req & ~a;
         if (n == 0) begin
            @(negedge sys_clk); #1;
            e = mk(0, 32'hc0a80020, 2);
            cli_ip[31:0] = e.ip;
            sb.push_back(e);
            cli_req[0] = 1'b1;
         end
      end
      cli_req = 4'd0;
      repeat (4) @(negedge sys_clk);
      #1;

      // mask: requester 2 keeps cli_req high after its ack
      e = mk(2, 32'h0a020202, 2);
      sb.push_back(e);
      cli_ip[95:64] = e.ip;
      cli_req = 4'b0100;
      wait_ack(d_ack, a);
      e = mk(2, 32'h0a020202, 3);
      sb.push_back(e);
      wait_fib_req(c);
      if (d_ack >= 0 && c >= 0) check("mask_regrant_cycle", 64'(c - d_ack), 64'd3);
      drain();
      repeat (4) @(negedge sys_clk);
      #1;

      // reset in the middle of WAIT, then late fib_ack lands in IDLE
      e = mk(1, 32'h0a000102, 6);
      sb.push_back(e);
      cli_ip[63:32] = e.ip;
      cli_req = 4'b0010;
      wait_fib_req(c);
      repeat (2) @(negedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      cli_req = 4'd0;
      @(negedge sys_clk); #1;
      check_outputs_zero("midreset");
      @(negedge sys_clk); #1;
      sys_rst_n = 1'b1;
      sb.delete();
      nreq = 0;
      repeat (8) @(negedge sys_clk);
      #1;
      check("post_reset_stat_grant", stat_grant_cnt, 64'd0);
      check("post_reset_stat_timeout", 64'(stat_timeout_cnt), 64'd0);

      // requesters 1 and 3 together: reset pointer must pick 1 first
      e = mk(1, 32'h0a000111, 2);
      sb.push_back(e);
      cli_ip[63:32] = e.ip;
      e = mk(3, 32'h0a000333, 4);
      sb.push_back(e);
      cli_ip[127:96] = e.ip;
      cli_req = 4'b1010;
      drain();
      repeat (2) @(negedge sys_clk);
      #1;
`ifdef LOOKUPFIB_ARB_STATS_EN
      check("stat_grant_cnt", stat_grant_cnt, 64'h0001_0000_0001_0000);
`else
      check("stat_grant_cnt", stat_grant_cnt, 64'd0);
`endif
      check("stat_timeout_cnt", 64'(stat_timeout_cnt), 64'd0);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
